fft_input_sequencer: RTL and testbench
======================================

Name: fft_input_sequencer

Overview:
Streaming front-end for the 8-point radix-2 FFT. It accepts one real sample per cycle over a valid/ready handshake and scatters each sample into a ping-pong register bank at its bit-reversed address. It then presents each completed 8-sample frame, already in bit-reversed order, to the first butterfly stage over a frame-wide valid/ready handshake. Two banks allow a full-rate input stream while the downstream stage consumes the previous frame.

Parameters:
WIDTH, 16, signed sample width in bits
FFT size fixed at 8; it is not a parameter.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  1  input sample valid
s_ready  output  1  sequencer can accept a sample this cycle
s_data  input  signed [WIDTH-1:0]  input sample, natural time order
m_valid  output  1  complete reordered frame available
m_ready  input  1  downstream accepts frame
m_data  output  signed [WIDTH-1:0] x [7:0]  frame; m_data[j] = input sample bitrev3(j) of the frame

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State:
  - two banks B0/B1, each 8 x WIDTH registers plus a full flag;
  - wr_bank, rd_bank (1 bit each);
  - wr_idx (3-bit counter).
- Reset values:
  - wr_idx=0, wr_bank=0, rd_bank=0;
  - both full flags 0; all bank registers 0;
  - m_valid=0, m_data all 0;
  - s_ready=0 while rst is high, 1 on the first cycle after release.
- Write path:
  - s_ready = !full[wr_bank]; it depends on registered state only, with no combinational path from m_ready.
  - On s_valid && s_ready: bank[wr_bank][bitrev3(wr_idx)] <= s_data, then wr_idx++.
  - When wr_idx==7 is accepted: full[wr_bank]<=1, wr_bank toggles, wr_idx wraps to 0.
- Read path:
  - m_valid = full[rd_bank]; m_data = bank[rd_bank], driven straight from registers.
  - On m_valid && m_ready: full[rd_bank]<=0, rd_bank toggles.
- Per-bank state machine: EMPTY -> FILLING (first sample written) -> FULL (8th sample) -> EMPTY (frame accepted). FILLING is implied by wr_bank==bank && wr_idx!=0.
- Latency: 8th sample accepted at cycle t gives m_valid=1 at t+1.
- Throughput: with m_ready tied high, s_ready never deasserts (100% input rate).
- Simultaneous events:
  - Completing a frame into one bank while the other is drained in the same cycle is legal; both updates apply.
  - A bank freed at cycle t is writable (s_ready=1) from t+1.
- Both banks full: s_ready=0. Stalled input holds wr_idx; no sample is dropped or overwritten.
- m_data holding: stable while m_valid && !m_ready. A frame is never modified while it is presented.
- Reset mid-operation: any partial frame and any full unconsumed frames are discarded; state returns to reset values.
- bitrev3(k) = {k[0],k[1],k[2]}: 0,4,2,6,1,5,3,7 for k=0..7.

Optional Feature:
Macro: FFT_SEQ_FRAME_TAG_EN.
- Defined:
  - adds output m_tag [7:0], the frame sequence number;
  - each bank stores the tag captured when its frame completes;
  - a write-side tag counter starts at 0 at reset and increments per completed frame, wrapping 255->0;
  - m_tag is valid with m_valid.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fft_pkg holds:
  - FFT_N=8, FFT_LOG2N=3;
  - typedef sample_t (signed [WIDTH-1:0]) and frame_t (sample_t [FFT_N-1:0]);
  - function bitrev3.
- Sub-module fft_seq_bank: one 8-entry register bank with indexed write, full flag set/clear, and frame-wide read. Instantiated twice.

Test Plan:
- Reset release, stream 0..7 with m_ready=1 -> m_valid one cycle after the 8th sample; m_data = {0,4,2,6,1,5,3,7} (index 0 first).
- m_ready=0, stream 24 samples 0..23 -> two frames buffered; s_ready=0 after sample 15; samples 16+ stall with no loss. Raise m_ready -> frames {0,4,2,6,1,5,3,7}, then {8,12,10,14,9,13,11,15}, then third frame correct.
- Continuous 64-sample stream with m_ready=1 -> s_ready never low; 8 frames, each correctly bit-reversed.
- Random s_valid/m_ready gaps, 1000 frames -> scoreboard matches bitrev3 ordering; m_data stable during every stall.
- Assert rst after 5 samples of a frame and with one full frame pending -> m_valid=0 and s_ready=0 during reset. Next 8 samples 100..107 -> {100,104,102,106,101,105,103,107}.
- With FFT_SEQ_FRAME_TAG_EN: stream 257 frames -> m_tag runs 0..255, 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point FFT input sequencer.
// Fixed FFT size; sample width in types is the default build width.
package fft_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_LOG2N = 3;
  localparam int FFT_W     = 16;

  typedef logic signed [FFT_W-1:0] sample_t;
  typedef sample_t [FFT_N-1:0]     frame_t;

  // Reverse the three address bits: 0,4,2,6,1,5,3,7 for k=0..7
  function automatic logic [FFT_LOG2N-1:0] bitrev3(
    input logic [FFT_LOG2N-1:0] k
  );
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_seq_bank.sv
// One 8-entry sample bank with indexed write, full flag and frame read.
// Optional macro FFT_SEQ_FRAME_TAG_EN adds a per-bank frame tag.
module fft_seq_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_we,
  input  logic [FFT_LOG2N-1:0]           i_widx,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_set_full,
  input  logic                           i_clr_full,
`ifdef FFT_SEQ_FRAME_TAG_EN
  input  logic [7:0]                     i_tag,
  output logic [7:0]                     o_tag,
`endif
  output logic                           o_full,
  output logic [FFT_N-1:0][WIDTH-1:0]    o_frame
);

  logic [FFT_N-1:0][WIDTH-1:0] r_mem;
  logic                        r_full;

  // Sample storage and full flag; writes only land while not full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_we)
        r_mem[i_widx] <= i_wdata;
      if (i_set_full)
        r_full <= 1'b1;
      else if (i_clr_full)
        r_full <= 1'b0;
    end
  end

`ifdef FFT_SEQ_FRAME_TAG_EN
  logic [7:0] r_tag;

  // Capture the frame number when this bank's frame completes
  always_ff @(posedge clk) begin
    if (rst)
      r_tag <= '0;
    else if (i_set_full)
      r_tag <= i_tag;
  end

  assign o_tag = r_tag;
`endif

  assign o_full  = r_full;
  assign o_frame = r_mem;

endmodule

// File: rtl/fft_input_sequencer.sv
// Streaming bit-reverse front-end for the 8-point FFT, ping-pong banks.
// Optional macro FFT_SEQ_FRAME_TAG_EN adds the m_tag frame number output.
module fft_input_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_data [FFT_N-1:0]
`ifdef FFT_SEQ_FRAME_TAG_EN
  ,
  output logic [7:0]              m_tag
`endif
);

  logic                   r_wr_bank;
  logic                   r_rd_bank;
  logic [FFT_LOG2N-1:0]   r_wr_idx;

  logic [1:0]                        w_full;
  logic [1:0][FFT_N-1:0][WIDTH-1:0]  w_frame;
  logic                              w_accept;
  logic                              w_last;
  logic                              w_drain;
  logic [FFT_LOG2N-1:0]              w_widx;

`ifdef FFT_SEQ_FRAME_TAG_EN
  logic [7:0]       r_tag_cnt;
  logic [1:0][7:0]  w_tag;
`endif

  assign s_ready  = !rst && !w_full[r_wr_bank];
  assign m_valid  = w_full[r_rd_bank];
  assign w_accept = s_valid && s_ready;
  assign w_last   = w_accept &&
                    (r_wr_idx == FFT_LOG2N'(FFT_N - 1));
  assign w_drain  = m_valid && m_ready;
  assign w_widx   = bitrev3(r_wr_idx);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    localparam logic B = 1'(g);

    fft_seq_bank #(
      .WIDTH (WIDTH)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_accept && (r_wr_bank == B)),
      .i_widx     (w_widx),
      .i_wdata    (s_data),
      .i_set_full (w_last && (r_wr_bank == B)),
      .i_clr_full (w_drain && (r_rd_bank == B)),
`ifdef FFT_SEQ_FRAME_TAG_EN
      .i_tag      (r_tag_cnt),
      .o_tag      (w_tag[g]),
`endif
      .o_full     (w_full[g]),
      .o_frame    (w_frame[g])
    );
  end

  // Write pointer: advance per accepted sample, flip bank on 8th
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_accept) begin
      r_wr_idx <= r_wr_idx + 1'b1;
      if (w_last)
        r_wr_bank <= ~r_wr_bank;
    end
  end

  // Read pointer: flip bank when the presented frame is taken
  always_ff @(posedge clk) begin
    if (rst)
      r_rd_bank <= 1'b0;
    else if (w_drain)
      r_rd_bank <= ~r_rd_bank;
  end

`ifdef FFT_SEQ_FRAME_TAG_EN
  // Frame number counter, bumped as each frame completes
  always_ff @(posedge clk) begin
    if (rst)
      r_tag_cnt <= '0;
    else if (w_last)
      r_tag_cnt <= r_tag_cnt + 1'b1;
  end

  assign m_tag = w_tag[r_rd_bank];
`endif

  // Present the read bank straight from its registers
  always_comb begin
    for (int j = 0; j < FFT_N; j++)
      m_data[j] = w_frame[r_rd_bank][j];
  end

endmodule

// File: tb/tb_fft_input_sequencer.sv
// Scoreboard bench for fft_input_sequencer.
// Tag checks enabled when FFT_SEQ_FRAME_TAG_EN is defined.
module tb_fft_input_sequencer;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [W-1:0] s_data = '0;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic signed [W-1:0] m_data [7:0];
`ifdef FFT_SEQ_FRAME_TAG_EN
  logic [7:0]          m_tag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int BR [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [127:0] sb_q [$];
  logic [7:0]   tag_q [$];
  logic [127:0] cur = '0;
  int           widx = 0;
  logic [7:0]   tagc = '0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_frame = '0;
  bit           done = 1'b0;

  always #5 clk = ~clk;

  fft_input_sequencer #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef FFT_SEQ_FRAME_TAG_EN
    ,
    .m_tag   (m_tag)
`endif
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_out();
    logic [127:0] f;
    f = '0;
    for (int j = 0; j < 8; j++)
      f[j*16 +: 16] = m_data[j];
    return f;
  endfunction

  function automatic logic [127:0] mk(input int base);
    logic [127:0] f;
    f = '0;
    for (int j = 0; j < 8; j++)
      f[j*16 +: 16] = 16'(base + BR[j]);
    return f;
  endfunction

  // Monitor: handshakes seen here commit at the following posedge
  always @(negedge clk) begin
    logic [127:0] obs;
    obs = pack_out();
    if (rst) begin
      sb_q.delete();
      tag_q.delete();
      widx = 0;
      tagc = '0;
      cur = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", obs, prev_frame);
      end
      if (s_valid && s_ready) begin
        cur[BR[widx]*16 +: 16] = s_data;
        widx++;
        if (widx == 8) begin
          sb_q.push_back(cur);
          tag_q.push_back(tagc);
          tagc++;
          widx = 0;
        end
      end
      if (m_valid && m_ready) begin
        chk("sb_level", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          chk("frame", obs, sb_q.pop_front());
`ifdef FFT_SEQ_FRAME_TAG_EN
          chk("tag", m_tag, tag_q.pop_front());
`else
          void'(tag_q.pop_front());
`endif
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_frame = obs;
    end
  end

  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = v[15:0];
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_ok", ok, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb_q.size() != 0; n++)
      @(negedge clk);
    chk("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", pack_out(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // first frame and latency
    m_ready = 1'b1;
    for (int k = 0; k < 7; k++)
      send(k);
    chk("pre_valid", m_valid, 0);
    send(7);
    chk("lat_valid", m_valid, 1);
    chk("t1_data", pack_out(), mk(0));
    drain();

    // both banks fill, input stalls without loss
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++)
      send(k);
    chk("full_stall", s_ready, 0);
    chk("full_valid", m_valid, 1);
    chk("t2_head", pack_out(), mk(0));
    fork
      begin
        for (int k = 16; k < 24; k++)
          send(k);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("still_stall", s_ready, 0);
        m_ready = 1'b1;
      end
    join
    drain();

    // full-rate stream
    m_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 64; k++)
          send(1000 + k);
      end
      begin
        repeat (64) begin
          @(negedge clk);
          chk("cont_ready", s_ready, 1);
        end
      end
    join
    drain();

    // random gaps on both sides
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 1000; f++)
          for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
              s_valid = 1'b0;
              @(posedge clk);
              #1;
            end
            send(int'($urandom_range(0, 65535)));
          end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 2) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();

    // reset with a full frame pending and a partial one
    m_ready = 1'b0;
    for (int k = 0; k < 13; k++)
      send(200 + k);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_ready", s_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++)
      send(100 + k);
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_data", pack_out(), mk(100));
    drain();

`ifdef FFT_SEQ_FRAME_TAG_EN
    // tag wrap: 257 frames from reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 257 * 8; k++)
      send(k);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
